uart_rx_core: RTL

- Serial UART receiver directly upstream of the UART Wishbone controller.
- Oversamples the asynchronous RX line and deserialises 8N1 frames (1 start, 8 data LSB-first, 1 stop, no parity).
- Delivers each good byte with a one-cycle irq/push strobe.
- Reports busy and framing-error status, and holds an error until the controller acknowledges it with rx_finish.

---
 rtl/uart_rx_if.sv | 11 +
 rtl/uart_rx_core.sv | 80 ++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: receiver-to-controller signals (serial line in, byte strobe and status out)
interface uart_rx_if;
  logic       i_rx_line;
  logic       i_rx_finish;
  logic [7:0] o_rx_data;
  logic       o_irq;
  logic       o_rx_busy;
  logic       o_frame_err;
  modport master (output i_rx_line, i_rx_finish, input o_rx_data, o_irq, o_rx_busy, o_frame_err);
  modport slave (input i_rx_line, i_rx_finish, output o_rx_data, o_irq, o_rx_busy, o_frame_err);
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling 8N1 UART receiver with byte strobe and held framing error
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W = 16
) (
  input logic      clk,
  input logic      rst_n,
  uart_rx_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, ERR} state_t;
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  state_t           state;
  logic [2:0]       sync;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             rx_s, rx_prev;
  assign rx_s = sync[1];
  assign rx_prev = sync[2];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync <= 3'b111;
    else sync <= {sync[1:0], bus.i_rx_line};
  // Bit sampling lands mid-bit: half a period into the start bit, then a full period per bit.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift_reg <= '0;
      bus.o_rx_data <= '0;
      bus.o_irq <= 1'b0;
      bus.o_rx_busy <= 1'b0;
      bus.o_frame_err <= 1'b0;
    end else begin
      bus.o_irq <= 1'b0;
      case (state)
        IDLE:
          if (rx_prev && !rx_s) begin
            state <= START;
            clk_cnt <= '0;
            bus.o_rx_busy <= 1'b1;
          end
        START:
          if (clk_cnt == HALF) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state <= rx_s ? IDLE : DATA;
            bus.o_rx_busy <= !rx_s;
          end else clk_cnt <= clk_cnt + 1'b1;
        DATA:
          if (clk_cnt == FULL) begin
            clk_cnt <= '0;
            shift_reg[bit_idx] <= rx_s;
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= STOP;
          end else clk_cnt <= clk_cnt + 1'b1;
        STOP:
          if (clk_cnt == FULL) begin
            clk_cnt <= '0;
            if (rx_s) begin
              bus.o_rx_data <= shift_reg;
              bus.o_irq <= 1'b1;
              bus.o_rx_busy <= 1'b0;
              state <= IDLE;
            end else begin
              bus.o_frame_err <= 1'b1;
              state <= ERR;
            end
          end else clk_cnt <= clk_cnt + 1'b1;
        ERR:
          if (bus.i_rx_finish) begin
            bus.o_frame_err <= 1'b0;
            bus.o_rx_busy <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule
